// File: rtl/div_iter_unit.sv
// div_iter_unit -- multi-cycle restoring divider for DIV/DIVU in EX.
//
// Result packing: result_o = {remainder, quotient}. The remainder goes to HI
// and the quotient goes to LO.
//
// Ports:
//   clk, rst      rising-edge clock and synchronous active-high reset
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     dividend, latched when the operation is accepted
//   opdata2_i     divisor, latched when the operation is accepted
//   start_i       request; held high until ready_o has been seen
//   annul_i       flushes an operation that is in flight
//   result_o      {remainder[2W-1:W], quotient[W-1:0]}
//   ready_o       result valid; held until start_i drops
//
// Latency from the acceptance edge: WIDTH edges for a normal division, and
// 1 edge for a divide by zero.
//
// Optional build macro DIV_EARLY_TERM_EN: when |dividend| < |divisor| the
// operation completes after 1 edge. The result is the same as the full
// iteration produces; only the latency changes.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    // Upper WIDTH+1 bits hold the partial remainder. The lower WIDTH bits
    // start as the dividend magnitude and fill with quotient bits.
    logic [2*WIDTH:0]   sreg;
    logic [WIDTH-1:0]   divisor_r;
    logic               sq, sr;

    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH:0]   shifted, step;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   fin_q, fin_r, q_out, r_out;
    logic               done;

`ifdef DIV_EARLY_TERM_EN
    logic               early_r;
`endif

    // Operand magnitudes. These are used only at acceptance.
    always_comb begin
        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    end

    // One restoring step: shift left, then try to subtract the divisor from
    // the upper part.
    always_comb begin
        shifted = {sreg[2*WIDTH-1:0], 1'b0};
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_r};
        if (!diff[WIDTH])
            step = {diff, shifted[WIDTH-1:1], 1'b1};
        else
            step = shifted;
    end

    always_comb begin
`ifdef DIV_EARLY_TERM_EN
        // On the early path, sreg still holds |dividend|. Applying the sign
        // correction below restores the original dividend as the remainder.
        fin_q = early_r ? '0 : step[WIDTH-1:0];
        fin_r = early_r ? sreg[WIDTH-1:0] : step[2*WIDTH-1:WIDTH];
        done  = early_r || (cnt == CNT_W'(WIDTH-1));
`else
        fin_q = step[WIDTH-1:0];
        fin_r = step[2*WIDTH-1:WIDTH];
        done  = (cnt == CNT_W'(WIDTH-1));
`endif
        q_out = sq ? -fin_q : fin_q;
        r_out = sr ? -fin_r : fin_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FREE;
            cnt       <= '0;
            sreg      <= '0;
            divisor_r <= '0;
            sq        <= 1'b0;
            sr        <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
`ifdef DIV_EARLY_TERM_EN
            early_r   <= 1'b0;
`endif
        end else begin
            case (state)
                S_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else begin
                            sreg      <= {{(WIDTH+1){1'b0}}, mag1};
                            divisor_r <= mag2;
                            sq        <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            sr        <= signed_div_i & opdata1_i[WIDTH-1];
                            cnt       <= '0;
                            state     <= S_ON;
`ifdef DIV_EARLY_TERM_EN
                            early_r   <= (mag1 < mag2);
`endif
                        end
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state <= S_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state <= S_FREE;
                        cnt   <= '0;
                    end else if (done) begin
                        result_o <= {r_out, q_out};
                        ready_o  <= 1'b1;
                        state    <= S_END;
                    end else begin
                        sreg <= step;
                        cnt  <= cnt + 1'b1;
                    end
                end
                S_END: begin
                    // Holding start_i keeps the result. No restart happens.
                    if (!start_i) begin
                        state    <= S_FREE;
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;

`ifdef DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div, start, annul;
    logic [31:0] op1, op2;
    logic [63:0] result;
    logic        ready;

    logic        s8, start8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;
    logic        ready8;

    int vectors = 0;
    int miscompares = 0;

    div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div),
        .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready)
    );

    div_iter_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst(rst), .signed_div_i(s8),
        .opdata1_i(a8), .opdata2_i(b8), .start_i(start8), .annul_i(1'b0),
        .result_o(result8), .ready_o(ready8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero. The
    // remainder takes the dividend's sign.
    function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 0) return 64'd0;
        if (sg) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        q = la / lb;
        r = la % lb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] mag(input bit sg, input logic [31:0] a);
        return (sg && a[31]) ? -a : a;
    endfunction

    function automatic int exp_lat(input bit sg, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (EARLY && mag(sg, a) < mag(sg, b)) return 1;
        return 32;
    endfunction

    // Count edges from the acceptance edge until ready. Operands are
    // scrambled after acceptance to check that they were latched.
    task automatic run_op(input string tag, input bit sg, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int n;
        logic [63:0] exp;
        exp = model(sg, a, b);
        signed_div = sg; op1 = a; op2 = b; start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 1) begin op1 = $urandom; op2 = $urandom; end
        end while (!ready && n < 200);
        chk({tag, "_lat"}, 64'(n - 1), 64'(exp_lat(sg, a, b)));
        chk({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {result, 63'd0} | 64'(ready), {exp, 63'd0} | 64'd1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_clr"}, {63'd0, ready} | result, 64'd0);
    endtask

    initial begin
        int n, seen;
        bit sg;
        logic [31:0] a, b;

        rst = 1'b1; signed_div = 0; op1 = 0; op2 = 0; start = 0; annul = 0;
        s8 = 0; a8 = 0; b8 = 0; start8 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op("divu_100_7", 0, 32'd100, 32'd7, 0);
        run_op("div_m5_2", 1, 32'hFFFFFFFB, 32'd2, 0);
        run_op("div_30_m5", 1, 32'h1E, 32'hFFFFFFFB, 0);
        run_op("div_ovf", 1, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("divu_big", 0, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op("div_byzero", 1, 32'h1234, 32'd0, 5);
        run_op("divu_byzero", 0, 32'hFFFF, 32'd0, 0);
        run_op("div_small", 1, 32'hFFFFFFFD, 32'd10, 0);

        // Annul at iteration 10 with start dropped. ready must never rise.
        signed_div = 0; op1 = 1000; op2 = 7; start = 1;
        repeat (11) @(posedge clk);
        #1; annul = 1; start = 0;
        @(posedge clk); #1;
        chk("annul_clr", {63'd0, ready} | result, 64'd0);
        annul = 0; seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ready) seen++; end
        chk("annul_never_ready", 64'(seen), 64'd0);

        // Annul with start still high. The new operation is accepted on the
        // edge after FREE is re-entered.
        op1 = 77; op2 = 5; start = 1;
        repeat (6) @(posedge clk);
        #1; annul = 1;
        @(posedge clk); #1;
        chk("annul2_clr", 64'(ready), 64'd0);
        annul = 0; n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 200);
        chk("annul2_lat", 64'(n), 64'(exp_lat(0, 77, 5) + 1));
        chk("annul2_res", result, model(0, 77, 5));
        start = 0;
        @(posedge clk); #1;

        // Reset in the middle of an operation
        op1 = 32'hDEAD; op2 = 3; start = 1;
        repeat (10) @(posedge clk);
        #1; rst = 1; start = 0;
        @(posedge clk); #1;
        chk("midrst", {63'd0, ready} | result, 64'd0);
        rst = 0;
        @(posedge clk); #1;
        run_op("after_rst_9_3", 0, 32'd9, 32'd3, 0);

        // Randomized operations, biased toward small and zero divisors
        for (int k = 0; k < 30; k++) begin
            sg = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 15);
                1: begin b = $urandom; a = $urandom_range(0, 100); end
                default: b = $urandom;
            endcase
            run_op("rand", sg, a, b, 0);
        end

        // WIDTH=8: DIVU 3/10
        s8 = 0; a8 = 8'd3; b8 = 8'd10; start8 = 1; n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready8 && n < 50);
        chk("w8_lat", 64'(n - 1), EARLY ? 64'd1 : 64'd8);
        chk("w8_res", 64'(result8), 64'h0300);
        start8 = 0;
        @(posedge clk); #1;
        chk("w8_clr", 64'(result8) | 64'(ready8), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Parametrised multi-cycle restoring divider for the openMIPS execute stage. Implements DIV/DIVU.
- Produces a {remainder, quotient} pair. The remainder goes to HI and the quotient goes to LO via the EX/MEM HI/LO write path.
- Replaces single-cycle arithmetic for division. EX stalls the pipeline while start_i is high and ready_o is low.

Parameters:
- WIDTH, 32, operand width in bits. Must be ≥4. Result width is 2*WIDTH.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  WIDTH  dividend
- opdata2_i  input  WIDTH  divisor
- start_i  input  1  request. EX holds it high until it sees ready_o.
- annul_i  input  1  abort the in-flight division (branch/exception flush)
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}
- ready_o  output  1  result valid

Behaviour:
- All outputs are registered.
- Reset (rst=1 at any edge, including mid-operation):
  - state goes to FREE
  - ready_o=0, result_o=0, counter=0
  - internal dividend/divisor registers are cleared
- States: FREE, BYZERO, ON, END.
- FREE:
  - ready_o=0, result_o=0.
  - On an edge with start_i=1 and annul_i=0 (the acceptance edge E0):
    - if opdata2_i==0, go to BYZERO
    - else latch operands and signed_div_i, and go to ON with counter=0
- Signed mode latch:
  - Operands are converted to magnitudes.
  - Latched signs: sq = msb1^msb2 (quotient), sr = msb1 (remainder).
  - Unsigned mode uses raw values, with sq=sr=0.
- ON:
  - One restoring iteration per edge on a 2*WIDTH+1 shift register.
  - Subtract divisor from the upper part. If the result is non-negative, keep it and shift in 1; else shift in 0.
  - counter increments each iteration.
  - On the edge where counter==WIDTH-1 (edge E_WIDTH), form the result:
    - apply sign correction: negate the quotient if sq, negate the remainder if sr
    - register result_o
    - set ready_o=1
    - go to END
- Latency:
  - ready_o is high after WIDTH edges following E0 (normal case).
  - ready_o is high after 1 edge following E0 for divide-by-zero.
- BYZERO: on the next edge, result_o=0, ready_o=1, go to END.
- END:
  - Holds result_o and ready_o.
  - When start_i==0 at an edge: go to FREE, ready_o=0, result_o=0.
  - While start_i stays 1, END persists, with no restart and no duplicate result.
- annul_i:
  - In ON or BYZERO: on the next edge go to FREE, ready_o=0, result_o=0, and the partial result is discarded.
  - In FREE: blocks acceptance.
  - In END: ignored; the END exit rule applies.
- annul_i and start_i together in FREE: annul_i wins and nothing is accepted.
- Back-to-back operations:
  - A new start is accepted only from FREE, so at least one cycle with start_i=0 separates operations.
  - Exception: after an annul, start_i may already be high on the edge that enters FREE; it is accepted on the following edge.
- Operand changes after E0 have no effect; operands are latched.
- Signed overflow case, -2^(WIDTH-1) / -1: quotient = -2^(WIDTH-1) (wraps), remainder = 0. No trap is raised.
- Sign rule: the remainder always takes the dividend's sign, and |remainder| < |divisor|.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- Defined:
  - At acceptance, when divisor≠0 and |dividend| < |divisor| (magnitudes after sign handling), go directly to END on the next edge.
  - Result is quotient=0, remainder=original dividend unchanged. ready_o is high after 1 edge.
  - The comparator is evaluated only in FREE.
- Undefined: no comparator is built, and all non-zero-divisor operations take WIDTH edges.
- Results must be bit-identical in both builds; only latency differs.

Test Plan:
- DIVU, WIDTH=32, 100/7 with start held → ready_o after 32 edges, result_o={0x00000002,0x0000000E}. Dropping start_i clears ready_o and result_o on the next edge.
- DIV 0xFFFFFFFB/0x00000002 (−5/2) → quotient 0xFFFFFFFE, remainder 0xFFFFFFFF. DIV 0x0000001E/0xFFFFFFFB → quotient 0xFFFFFFFA, remainder 0.
- DIV 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0x80000000/0xFFFFFFFF → quotient 0, remainder 0x80000000.
- Divisor 0 (DIV and DIVU) → ready_o after 1 edge, result_o=0. Hold start_i 5 extra cycles → stays in END, ready_o stays 1.
- annul_i pulse at iteration 10 → FREE on the next edge, ready_o never rises. rst mid-ON → all outputs 0. A new 9/3 start afterward → quotient 3, remainder 0 after 32 edges.
- WIDTH=8, DIVU 3/10: with DIV_EARLY_TERM_EN → ready after 1 edge, {0x03,0x00}. Without it → ready after 8 edges with the identical result.
